// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding, requester IDs and a small helper
// used by mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_IFETCH = 1'b0;
    localparam logic REQ_DATA   = 1'b1;

    // Preload for the WAIT countdown: WAIT lasts latency-1 cycles, and the
    // counter runs down to zero inclusive, so it starts at latency-2.
    function automatic logic [1:0] wait_preload(input int latency);
        return (latency >= 2) ? 2'(latency - 2) : 2'd0;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port block RAM between an instruction-fetch
// requester (read-only) and a data requester (read/write). One transaction is
// in flight at a time: IDLE -> ISSUE -> WAIT (MEM_LATENCY-1 cycles) -> RESP.
// The response (x_rvalid / x_rdata) is registered and appears the cycle after
// RESP, giving 2+MEM_LATENCY cycles from acceptance to rvalid.
// Optional build macro MEM_ARB_DATA_PRIORITY_EN: when defined, the data
// requester always wins a tie and no round-robin state exists; otherwise
// ties alternate, with fetch winning the first tie after reset.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch requester
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [XLEN-1:0]       i_rdata,
    // data requester
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [XLEN/8-1:0]     d_wstrb,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [XLEN-1:0]       d_wdata,
    output logic                  d_rvalid,
    output logic [XLEN-1:0]       d_rdata,
    // block-RAM side
    output logic                  mem_en,
    output logic [XLEN/8-1:0]     mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int STRB_W = XLEN / 8;
    localparam logic [1:0] WAIT_INIT = wait_preload(MEM_LATENCY);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  run_q;
    logic                  i_rvalid_q, d_rvalid_q;
    logic [XLEN-1:0]       i_rdata_q, d_rdata_q;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  accept_ok;
    logic                  accept;

`ifndef MEM_ARB_DATA_PRIORITY_EN
    logic                  last_q;

    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= REQ_DATA;
        end else if (accept) begin
            last_q <= grant_id;
        end
    end
`endif

    // Pick the requester to offer ready to: a lone requester directly,
    // a tie by priority or by round-robin.
    always_comb begin
        grant_valid = i_valid | d_valid;
        grant_id    = REQ_IFETCH;
        if (i_valid && d_valid) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
            grant_id = REQ_DATA;
`else
            grant_id = ~last_q;
`endif
        end else if (d_valid) begin
            grant_id = REQ_DATA;
        end
    end

    // Requests are taken only in IDLE, out of reset, and once the previous
    // response pulse has been delivered.
    assign accept_ok = run_q && (state_q == IDLE) && !i_rvalid_q && !d_rvalid_q;
    assign accept    = accept_ok && grant_valid;
    assign i_ready   = accept_ok && i_valid && (grant_id == REQ_IFETCH);
    assign d_ready   = accept_ok && d_valid && (grant_id == REQ_DATA);

    // Next-state logic: capture the request on acceptance, then walk the
    // memory access through ISSUE, the latency countdown and RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant_id;
                    if (grant_id == REQ_DATA) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wstrb_d = d_we ? d_wstrb : '0;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (MEM_LATENCY == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and captured-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_IFETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= 2'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    // Register the response for the owner only; rdata changes only together
    // with its rvalid pulse and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= (state_q == RESP) && (owner_q == REQ_IFETCH);
            d_rvalid_q <= (state_q == RESP) && (owner_q == REQ_DATA);
            if ((state_q == RESP) && (owner_q == REQ_IFETCH)) begin
                i_rdata_q <= mem_rdata;
            end
            if ((state_q == RESP) && (owner_q == REQ_DATA)) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = (state_q == ISSUE) ? wstrb_q : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: word-address width into block RAM.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, legal range 1..4: cycles from mem_en to valid mem_rdata.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports i_valid, i_ready, i_addr[ADDR_WIDTH], i_rvalid, i_rdata[XLEN]: instruction-fetch requester, read-only.
REQ-007 SHALL have ports d_valid, d_ready, d_we, d_wstrb[XLEN/8], d_addr[ADDR_WIDTH], d_wdata[XLEN], d_rvalid, d_rdata[XLEN]: data requester, read/write.
REQ-008 SHALL have ports mem_en, mem_we[XLEN/8], mem_addr[ADDR_WIDTH], mem_wdata[XLEN] as outputs and mem_rdata[XLEN] as input: single-port block-RAM side.

Function
REQ-009 SHALL use FSM states IDLE, ISSUE, WAIT and RESP.
REQ-010 SHALL assert x_ready combinationally only in IDLE and only for the granted requester; a request is accepted when x_valid && x_ready.
REQ-011 SHALL, on acceptance, register addr, wdata, and the write strobes (d_wstrb when d_we, else 0) plus the owner bit, then go to ISSUE.
REQ-012 SHALL drive mem_en=1 with the registered fields for exactly one cycle in ISSUE; mem_we SHALL be 0 for fetch requests.
REQ-013 SHALL count down MEM_LATENCY-1 cycles in WAIT; with MEM_LATENCY=1 it SHALL go directly ISSUE->RESP.
REQ-014 SHALL, in RESP, pulse the owner's x_rvalid for one cycle with x_rdata=mem_rdata, then return to IDLE; writes also receive the rvalid pulse as an acknowledgement.
REQ-015 SHALL give a total latency of 2+MEM_LATENCY cycles from the acceptance edge to rvalid, i.e. one transaction per 3+MEM_LATENCY cycles at most.
REQ-016 SHALL arbitrate round-robin: if both requesters are valid in IDLE, grant the one not served last; a lone requester is granted immediately.
REQ-017 SHALL not assert rvalid to the non-owner, and SHALL hold rdata outputs stable outside RESP.
REQ-018 SHALL not require a requester to hold valid after acceptance, and SHALL ignore changes to its address or data after acceptance.

Reset
REQ-019 SHALL, while reset is asserted, force the state to IDLE, mem_en=0, mem_we=0, both rvalid=0, both ready=0, rdata=0, and last-served=data (so fetch wins the first tie).
REQ-020 SHALL abandon any in-flight transaction on reset mid-operation and produce no rvalid for it afterwards.

Configuration
REQ-021 SHALL support macro MEM_ARB_DATA_PRIORITY_EN: when defined, the data requester always wins ties (fixed priority) and the round-robin state is not built; when undefined, the REQ-016 round-robin applies.

Structure
REQ-022 SHALL place the FSM state enum and the requester-ID constants (REQ_IFETCH=0, REQ_DATA=1) in the shared package mem_arb_pkg.
REQ-023 SHALL be a single module; the latency counter stays inline, with no sub-module.

Verification
REQ-024 The bench SHALL check a lone fetch: i_valid with i_addr=0x0010 where RAM[0x10]=0xDEADBEEF -> i_ready in the same cycle, mem_en one cycle later, i_rvalid=1 with i_rdata=0xDEADBEEF three cycles after acceptance (MEM_LATENCY=1).
REQ-025 The bench SHALL check a data write: d_we=1, d_wstrb=4'b0011, d_addr=0x0F00, d_wdata=0x12345678 over RAM value 0xAAAAAAAA -> mem_we=4'b0011, then a readback gives 0xAAAA5678.
REQ-026 The bench SHALL check a simultaneous tie after reset: i and d both valid -> fetch is granted first, then data, then fetch on a repeated tie; with MEM_ARB_DATA_PRIORITY_EN, data is granted every time.
REQ-027 The bench SHALL check MEM_LATENCY=3: a read accepted at cycle N -> mem_en at N+1 and rvalid at N+5, with no ready asserted between N and N+5.
REQ-028 The bench SHALL check reset in WAIT: reset pulsed during WAIT -> all outputs 0 immediately (asynchronous), no rvalid afterwards, and the next request is served normally.
